// File: rtl/lv_fault_int_ctrl_pkg.sv
// Shared widths, timing defaults and interrupt FSM encoding for the LV fault
// interrupt controller.
package lv_fault_int_ctrl_pkg;

  localparam int REG_DW       = 8;
  localparam int INTB_LOW_CYC = 16;
  localparam int INTB_GAP_CYC = 8;

  typedef enum logic [1:0] {
    INT_IDLE   = 2'd0,
    INT_ASSERT = 2'd1,
    INT_HOLD   = 2'd2,
    INT_GAP    = 2'd3
  } int_st_e;

  // Wide enough to hold the larger terminal count without wrapping.
  function automatic int cnt_w(input int low_cyc, input int gap_cyc);
    return $clog2(((low_cyc > gap_cyc) ? low_cyc : gap_cyc) + 1);
  endfunction

endpackage

// File: rtl/lv_fault_int_ctrl_flt_sticky.sv
// Sticky fault latch with write-1-to-clear; a live fault always overrides the
// clear for that bit.
module lv_flt_sticky #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] flt,
  input  logic [DW-1:0] clr,
  output logic [DW-1:0] lat,
  output logic [DW-1:0] lat_nxt
);

  assign lat_nxt = (lat & ~clr) | flt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lat <= '0;
    end else begin
      lat <= lat_nxt;
    end
  end

endmodule

// File: rtl/lv_fault_int_ctrl.sv
// LV fault reporting: sticky status latches with W1C clear, active-low interrupt
// pin with minimum low width and re-arm gap, and safe-state request.
//
// state      | meaning
// INT_IDLE   | pin high, waiting for any latched fault
// INT_ASSERT | pin low, timing the minimum low width
// INT_HOLD   | pin low, waiting for all latched faults to be cleared
// INT_GAP    | pin high, timing the minimum re-arm gap
module lv_fault_int_ctrl
  import lv_fault_int_ctrl_pkg::*;
#(
  parameter int REG_DW       = lv_fault_int_ctrl_pkg::REG_DW,
  parameter int INTB_LOW_CYC = lv_fault_int_ctrl_pkg::INTB_LOW_CYC,
  parameter int INTB_GAP_CYC = lv_fault_int_ctrl_pkg::INTB_GAP_CYC
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_DW-1:0] i_st1_flt,
  input  logic [REG_DW-1:0] i_st2_flt,
  input  logic              i_clr_vld,
  output logic              o_clr_rdy,
  input  logic              i_clr_sel,
  input  logic [REG_DW-1:0] i_clr_msk,
  output logic [REG_DW-1:0] o_flt_lat1,
  output logic [REG_DW-1:0] o_flt_lat2,
  output logic              o_intb_n,
  output logic              o_safe_req
);

  localparam int CNT_W = cnt_w(INTB_LOW_CYC, INTB_GAP_CYC);
  localparam logic [CNT_W-1:0] LOW_TC = CNT_W'(INTB_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_TC = CNT_W'(INTB_GAP_CYC - 1);

  int_st_e           int_st;
  logic [CNT_W-1:0]  cnt;
  logic              clr_acc;
  logic [REG_DW-1:0] clr1;
  logic [REG_DW-1:0] clr2;
  logic [REG_DW-1:0] lat1_nxt;
  logic [REG_DW-1:0] lat2_nxt;
  logic              any_flt;

  assign clr_acc = i_clr_vld & o_clr_rdy;
  assign clr1    = (clr_acc && !i_clr_sel) ? i_clr_msk : '0;
  assign clr2    = (clr_acc &&  i_clr_sel) ? i_clr_msk : '0;
  assign any_flt = (|o_flt_lat1) | (|o_flt_lat2);

  lv_flt_sticky #(.DW(REG_DW)) u_sticky1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .flt     (i_st1_flt),
    .clr     (clr1),
    .lat     (o_flt_lat1),
    .lat_nxt (lat1_nxt)
  );

  lv_flt_sticky #(.DW(REG_DW)) u_sticky2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .flt     (i_st2_flt),
    .clr     (clr2),
    .lat     (o_flt_lat2),
    .lat_nxt (lat2_nxt)
  );

  // Safe request follows the next latch value so it rises with the latch bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_clr_rdy  <= 1'b1;
      o_safe_req <= 1'b0;
    end else begin
      o_clr_rdy  <= ~clr_acc;
      o_safe_req <= |lat2_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      int_st   <= INT_IDLE;
      cnt      <= '0;
      o_intb_n <= 1'b1;
    end else begin
      case (int_st)
        INT_IDLE: begin
          o_intb_n <= 1'b1;
          if (any_flt) begin
            int_st   <= INT_ASSERT;
            cnt      <= '0;
            o_intb_n <= 1'b0;
          end
        end
        INT_ASSERT: begin
          o_intb_n <= 1'b0;
          if (cnt == LOW_TC) begin
            // Already cleared during the low window: release right at minimum width.
            if (any_flt) begin
              int_st <= INT_HOLD;
            end else begin
              int_st   <= INT_GAP;
              cnt      <= '0;
              o_intb_n <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INT_HOLD: begin
          o_intb_n <= 1'b0;
          if (!any_flt) begin
            int_st   <= INT_GAP;
            cnt      <= '0;
            o_intb_n <= 1'b1;
          end
        end
        INT_GAP: begin
          o_intb_n <= 1'b1;
          if (cnt == GAP_TC) begin
            int_st <= INT_IDLE;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          int_st   <= INT_IDLE;
          cnt      <= '0;
          o_intb_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lv_fault_int_ctrl.sv
// Directed bench for lv_fault_int_ctrl: latch timing, W1C clear rules,
// interrupt pin low width / re-arm gap, handshake turnaround and async reset.
module tb_lv_fault_int_ctrl;

  localparam int DW   = 8;
  localparam int LOW  = 16;
  localparam int GAP  = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [DW-1:0] i_st1_flt;
  logic [DW-1:0] i_st2_flt;
  logic          i_clr_vld;
  logic          o_clr_rdy;
  logic          i_clr_sel;
  logic [DW-1:0] i_clr_msk;
  logic [DW-1:0] o_flt_lat1;
  logic [DW-1:0] o_flt_lat2;
  logic          o_intb_n;
  logic          o_safe_req;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  lv_fault_int_ctrl #(
    .REG_DW       (DW),
    .INTB_LOW_CYC (LOW),
    .INTB_GAP_CYC (GAP)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_st1_flt  (i_st1_flt),
    .i_st2_flt  (i_st2_flt),
    .i_clr_vld  (i_clr_vld),
    .o_clr_rdy  (o_clr_rdy),
    .i_clr_sel  (i_clr_sel),
    .i_clr_msk  (i_clr_msk),
    .o_flt_lat1 (o_flt_lat1),
    .o_flt_lat2 (o_flt_lat2),
    .o_intb_n   (o_intb_n),
    .o_safe_req (o_safe_req)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_st1_flt = '0; i_st2_flt = '0;
    i_clr_vld = 1'b0; i_clr_sel = 1'b0; i_clr_msk = '0;
    #23;
    checks++; if (o_flt_lat1 !== 8'h00) begin errors++; $display("FAIL rst_lat1 got=%h exp=00", o_flt_lat1); end
    checks++; if (o_flt_lat2 !== 8'h00) begin errors++; $display("FAIL rst_lat2 got=%h exp=00", o_flt_lat2); end
    checks++; if (o_intb_n !== 1'b1) begin errors++; $display("FAIL rst_intb got=%b exp=1", o_intb_n); end
    checks++; if (o_safe_req !== 1'b0) begin errors++; $display("FAIL rst_safe got=%b exp=0", o_safe_req); end
    checks++; if (o_clr_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy got=%b exp=1", o_clr_rdy); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_st2_pulse();
    int lowc;
    i_st2_flt = 8'h80;
    step();
    i_st2_flt = 8'h00;
    checks++; if (o_flt_lat2 !== 8'h80) begin errors++; $display("FAIL st2_lat got=%h exp=80", o_flt_lat2); end
    checks++; if (o_safe_req !== 1'b1) begin errors++; $display("FAIL st2_safe got=%b exp=1", o_safe_req); end
    checks++; if (o_intb_n !== 1'b1) begin errors++; $display("FAIL st2_intb_early got=%b exp=1", o_intb_n); end
    step();
    checks++; if (o_intb_n !== 1'b0) begin errors++; $display("FAIL st2_intb_low got=%b exp=0", o_intb_n); end
    lowc = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_intb_n === 1'b0) lowc++;
    end
    // Latch never cleared, so the pin must stay low well past the minimum width.
    checks++; if (lowc != 21) begin errors++; $display("FAIL st2_low_width got=%0d exp=21", lowc); end
    i_clr_vld = 1'b1; i_clr_sel = 1'b1; i_clr_msk = 8'h80;
    step();
    i_clr_vld = 1'b0;
    checks++; if (o_flt_lat2 !== 8'h00) begin errors++; $display("FAIL st2_clr_lat got=%h exp=00", o_flt_lat2); end
    checks++; if (o_safe_req !== 1'b0) begin errors++; $display("FAIL st2_clr_safe got=%b exp=0", o_safe_req); end
    step();
    checks++; if (o_intb_n !== 1'b1) begin errors++; $display("FAIL st2_release got=%b exp=1", o_intb_n); end
    repeat (GAP + 2) step();
  endtask

  task automatic test_clr_timing();
    int lowc, fall1, rise1, fall2;
    lowc = 0; fall1 = -1; rise1 = -1; fall2 = -1;
    i_st1_flt = 8'h04;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (o_intb_n === 1'b0) begin
        if (fall1 < 0) fall1 = i;
        else if (rise1 >= 0 && fall2 < 0) fall2 = i;
        if (rise1 < 0) lowc++;
      end else if (fall1 >= 0 && rise1 < 0) begin
        rise1 = i;
      end
      if (i == 6) begin
        checks++; if (o_flt_lat1 !== 8'h00) begin errors++; $display("FAIL clr_lat1 got=%h exp=00", o_flt_lat1); end
      end
      if (i == 1) i_st1_flt = 8'h00;
      if (i == 5) begin i_clr_vld = 1'b1; i_clr_sel = 1'b0; i_clr_msk = 8'h04; end
      if (i == 6) i_clr_vld = 1'b0;
      if (i == 19) i_st1_flt = 8'h04;
      if (i == 20) i_st1_flt = 8'h00;
    end
    checks++; if (fall1 != 2) begin errors++; $display("FAIL clr_fall got=%0d exp=2", fall1); end
    checks++; if (lowc != LOW) begin errors++; $display("FAIL clr_low_width got=%0d exp=%0d", lowc, LOW); end
    checks++; if (rise1 != 2 + LOW) begin errors++; $display("FAIL clr_rise got=%0d exp=%0d", rise1, 2 + LOW); end
    // Gap cycles plus one idle cycle before the pending fault re-asserts.
    checks++; if (fall2 != 2 + LOW + GAP + 1) begin errors++; $display("FAIL clr_refall got=%0d exp=%0d", fall2, 2 + LOW + GAP + 1); end
    checks++; if (o_flt_lat1 !== 8'h04) begin errors++; $display("FAIL clr_relatch got=%h exp=04", o_flt_lat1); end
    i_clr_vld = 1'b1; i_clr_sel = 1'b0; i_clr_msk = 8'h04;
    step();
    i_clr_vld = 1'b0;
    repeat (30) step();
    checks++; if (o_intb_n !== 1'b1) begin errors++; $display("FAIL clr_idle got=%b exp=1", o_intb_n); end
  endtask

  task automatic test_live_wins();
    int lowc;
    i_st1_flt = 8'h08;
    step();
    checks++; if (o_flt_lat1 !== 8'h08) begin errors++; $display("FAIL live_lat got=%h exp=08", o_flt_lat1); end
    step();
    checks++; if (o_intb_n !== 1'b0) begin errors++; $display("FAIL live_intb got=%b exp=0", o_intb_n); end
    i_clr_vld = 1'b1; i_clr_sel = 1'b0; i_clr_msk = 8'h08;
    step();
    i_clr_vld = 1'b0;
    checks++; if (o_clr_rdy !== 1'b0) begin errors++; $display("FAIL live_rdy_low got=%b exp=0", o_clr_rdy); end
    checks++; if (o_flt_lat1 !== 8'h08) begin errors++; $display("FAIL live_kept got=%h exp=08", o_flt_lat1); end
    step();
    checks++; if (o_clr_rdy !== 1'b1) begin errors++; $display("FAIL live_rdy_back got=%b exp=1", o_clr_rdy); end
    lowc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_intb_n === 1'b0) lowc++;
    end
    checks++; if (lowc != 20) begin errors++; $display("FAIL live_pin_low got=%0d exp=20", lowc); end
    i_st1_flt = 8'h00;
    step();
    checks++; if (o_flt_lat1 !== 8'h08) begin errors++; $display("FAIL live_sticky got=%h exp=08", o_flt_lat1); end
    i_clr_vld = 1'b1; i_clr_msk = 8'h08;
    step();
    i_clr_vld = 1'b0;
    checks++; if (o_flt_lat1 !== 8'h00) begin errors++; $display("FAIL live_cleared got=%h exp=00", o_flt_lat1); end
    repeat (30) step();
    checks++; if (o_intb_n !== 1'b1) begin errors++; $display("FAIL live_idle got=%b exp=1", o_intb_n); end
  endtask

  task automatic test_set_wins();
    i_st2_flt = 8'h01;
    i_clr_vld = 1'b1; i_clr_sel = 1'b1; i_clr_msk = 8'h01;
    step();
    i_st2_flt = 8'h00; i_clr_vld = 1'b0;
    checks++; if (o_flt_lat2 !== 8'h01) begin errors++; $display("FAIL setwin_lat2 got=%h exp=01", o_flt_lat2); end
    checks++; if (o_safe_req !== 1'b1) begin errors++; $display("FAIL setwin_safe got=%b exp=1", o_safe_req); end
    step();
    i_clr_vld = 1'b1; i_clr_sel = 1'b1; i_clr_msk = 8'h01;
    step();
    i_clr_vld = 1'b0;
    checks++; if (o_flt_lat2 !== 8'h00) begin errors++; $display("FAIL setwin_clr got=%h exp=00", o_flt_lat2); end
    repeat (30) step();
  endtask

  task automatic test_back_to_back();
    i_st1_flt = 8'h03; i_st2_flt = 8'h10;
    step();
    i_st1_flt = 8'h00; i_st2_flt = 8'h00;
    checks++; if (o_flt_lat1 !== 8'h03) begin errors++; $display("FAIL b2b_lat1 got=%h exp=03", o_flt_lat1); end
    checks++; if (o_safe_req !== 1'b1) begin errors++; $display("FAIL b2b_safe got=%b exp=1", o_safe_req); end
    i_clr_vld = 1'b1; i_clr_sel = 1'b0; i_clr_msk = 8'h01;
    step();
    checks++; if (o_clr_rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdy0 got=%b exp=0", o_clr_rdy); end
    checks++; if (o_flt_lat1 !== 8'h02) begin errors++; $display("FAIL b2b_first got=%h exp=02", o_flt_lat1); end
    i_clr_msk = 8'h02;
    step();
    i_clr_vld = 1'b0;
    checks++; if (o_flt_lat1 !== 8'h02) begin errors++; $display("FAIL b2b_second_ignored got=%h exp=02", o_flt_lat1); end
    checks++; if (o_clr_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy1 got=%b exp=1", o_clr_rdy); end
    checks++; if (o_intb_n !== 1'b0) begin errors++; $display("FAIL b2b_assert got=%b exp=0", o_intb_n); end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_flt_lat1 !== 8'h00) begin errors++; $display("FAIL arst_lat1 got=%h exp=00", o_flt_lat1); end
    checks++; if (o_flt_lat2 !== 8'h00) begin errors++; $display("FAIL arst_lat2 got=%h exp=00", o_flt_lat2); end
    checks++; if (o_intb_n !== 1'b1) begin errors++; $display("FAIL arst_intb got=%b exp=1", o_intb_n); end
    checks++; if (o_safe_req !== 1'b0) begin errors++; $display("FAIL arst_safe got=%b exp=0", o_safe_req); end
    checks++; if (o_clr_rdy !== 1'b1) begin errors++; $display("FAIL arst_rdy got=%b exp=1", o_clr_rdy); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) step();
    checks++; if (o_intb_n !== 1'b1) begin errors++; $display("FAIL arst_after got=%b exp=1", o_intb_n); end
  endtask

  initial begin
    test_reset();
    test_st2_pulse();
    test_clr_timing();
    test_live_wins();
    test_set_wins();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
